lsu_spm_port: RTL and testbench

Load/store access stage sitting directly upstream of the dual-port scratchpad (SPM) on its MEM port. It accepts one memory micro-op at a time from the issue side over a valid/ready handshake and checks alignment, funct3 legality and range. It drives the SPM with a word-aligned address, big-endian byte enables and lane-placed store data, then returns sign/zero-extended load data with its tag over a second valid/ready handshake.

---
 rtl/lsu_spm_port.sv | 190 +++++++++++++++++++
 tb/tb_lsu_spm_port.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_spm_port.sv
// Load/store access stage in front of the scratchpad MEM port: one op in flight, IDLE -> ACC -> RESP.
// Optional build macro LSU_ACCESS_FAULT_EN: out-of-range addresses fault instead of wrapping.
//
// state  | meaning
// IDLE   | ready for a request; req_ready = ~flush
// ACC    | single SPM access cycle (strobes gated by flush)
// RESP   | response held until resp_ready or flush
module lsu_spm_port #(
  parameter int SPM_BYTES = 1024,
  parameter int TAG_W     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic [TAG_W-1:0] resp_tag,
  output logic [1:0]       resp_exc,
  output logic [31:0]      spm_rdaddress,
  output logic [31:0]      spm_wraddress,
  output logic             spm_rden,
  output logic             spm_wren,
  output logic [31:0]      spm_write_data,
  output logic [3:0]       spm_store_byteena,
  input  logic [31:0]      spm_rd_data
);

  localparam logic [31:0] ADDR_MASK = 32'(SPM_BYTES - 1) & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_RESP} state_e;

  state_e             state_q;
  logic               we_q;
  logic [2:0]         funct3_q;
  logic [1:0]         off_q;
  logic [1:0]         exc_q;
  logic [TAG_W-1:0]   tag_q;
  logic [31:0]        spm_addr_q;
  logic               rden_q;
  logic               wren_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic               resp_valid_q;
  logic [31:0]        resp_rdata_q;
  logic [TAG_W-1:0]   resp_tag_q;
  logic [1:0]         resp_exc_q;

  logic               illegal;
  logic               misaligned;
  logic               fault;
  logic [1:0]         exc_d;
  logic [31:0]        addr_d;
  logic [31:0]        wd_d;
  logic [3:0]         be_d;
  logic [31:0]        rd_shift;
  logic [31:0]        load_ext;

  always_comb begin
    illegal    = req_we ? (req_funct3 >= 3'b011)
                        : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                 (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`ifdef LSU_ACCESS_FAULT_EN
    fault      = (req_addr >= 32'(SPM_BYTES));
`else
    fault      = 1'b0;
`endif
    if (illegal)         exc_d = 2'b11;
    else if (misaligned) exc_d = 2'b01;
    else if (fault)      exc_d = 2'b10;
    else                 exc_d = 2'b00;

    addr_d = {req_addr[31:2], 2'b00} & ADDR_MASK;

    // Big-endian lanes: offset 0 lives in bits 31:24
    be_d = 4'b0000;
    wd_d = 32'h0;
    if (req_we && exc_d == 2'b00) begin
      case (req_funct3[1:0])
        2'b00: begin
          be_d = 4'b1000 >> req_addr[1:0];
          wd_d = {req_wdata[7:0], 24'h0} >> {req_addr[1:0], 3'b000};
        end
        2'b01: begin
          be_d = req_addr[1] ? 4'b0011 : 4'b1100;
          wd_d = req_addr[1] ? {16'h0, req_wdata[15:0]} : {req_wdata[15:0], 16'h0};
        end
        default: begin
          be_d = 4'b1111;
          wd_d = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    rd_shift = spm_rd_data << {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{rd_shift[31]}}, rd_shift[31:24]};
      3'b001:  load_ext = {{16{rd_shift[31]}}, rd_shift[31:16]};
      3'b010:  load_ext = spm_rd_data;
      3'b100:  load_ext = {24'h0, rd_shift[31:24]};
      3'b101:  load_ext = {16'h0, rd_shift[31:16]};
      default: load_ext = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
      exc_q        <= 2'b00;
      tag_q        <= '0;
      spm_addr_q   <= 32'h0;
      rden_q       <= 1'b0;
      wren_q       <= 1'b0;
      wdata_q      <= 32'h0;
      be_q         <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_tag_q   <= '0;
      resp_exc_q   <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && !flush) begin
            we_q       <= req_we;
            funct3_q   <= req_funct3;
            off_q      <= req_addr[1:0];
            exc_q      <= exc_d;
            tag_q      <= req_tag;
            spm_addr_q <= (exc_d == 2'b00) ? addr_d : 32'h0;
            rden_q     <= (exc_d == 2'b00) && !req_we;
            wren_q     <= (exc_d == 2'b00) && req_we;
            wdata_q    <= wd_d;
            be_q       <= be_d;
            state_q    <= S_ACC;
          end
        end
        S_ACC: begin
          spm_addr_q <= 32'h0;
          rden_q     <= 1'b0;
          wren_q     <= 1'b0;
          wdata_q    <= 32'h0;
          be_q       <= 4'b0000;
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= (!we_q && exc_q == 2'b00) ? load_ext : 32'h0;
            resp_tag_q   <= tag_q;
            resp_exc_q   <= exc_q;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          if (flush || resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // flush in the ACC cycle must suppress the strobe of that same cycle
  assign req_ready         = (state_q == S_IDLE) && !flush;
  assign spm_rden          = rden_q && !flush;
  assign spm_wren          = wren_q && !flush;
  assign spm_rdaddress     = spm_addr_q;
  assign spm_wraddress     = spm_addr_q;
  assign spm_write_data    = wdata_q;
  assign spm_store_byteena = be_q;
  assign resp_valid        = resp_valid_q;
  assign resp_rdata        = resp_rdata_q;
  assign resp_tag          = resp_tag_q;
  assign resp_exc          = resp_exc_q;

endmodule

// File: tb/tb_lsu_spm_port.sv
// Directed bench for lsu_spm_port with a big-endian word SPM model on the MEM port.
module tb_lsu_spm_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [5:0]  req_tag;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [5:0]  resp_tag;
  logic [1:0]  resp_exc;
  logic [31:0] spm_rdaddress;
  logic [31:0] spm_wraddress;
  logic        spm_rden;
  logic        spm_wren;
  logic [31:0] spm_write_data;
  logic [3:0]  spm_store_byteena;
  logic [31:0] spm_rd_data;

  int n_cmp = 0;
  int n_err = 0;

  logic        acc_rden, acc_wren;
  logic [3:0]  acc_be;
  logic [31:0] acc_wd, acc_wa, acc_ra;
  logic        r_valid, r_after;
  logic [31:0] r_rdata;
  logic [5:0]  r_tag;
  logic [1:0]  r_exc;

  always #5 clk = ~clk;

  lsu_spm_port #(.SPM_BYTES(1024), .TAG_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_tag(resp_tag), .resp_exc(resp_exc),
    .spm_rdaddress(spm_rdaddress), .spm_wraddress(spm_wraddress),
    .spm_rden(spm_rden), .spm_wren(spm_wren),
    .spm_write_data(spm_write_data), .spm_store_byteena(spm_store_byteena),
    .spm_rd_data(spm_rd_data)
  );

  logic [31:0] spm_mem [0:255] = '{default: 32'h0};
  assign spm_rd_data = spm_mem[spm_rdaddress[9:2]];
  always @(posedge clk) begin
    if (spm_wren)
      for (int i = 0; i < 4; i++)
        if (spm_store_byteena[3-i])
          spm_mem[spm_wraddress[9:2]][31-8*i -: 8] <= spm_write_data[31-8*i -: 8];
  end

  // Leaves the bench at the negedge of the ACC cycle with the SPM-side values captured.
  task automatic start_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [5:0] tag);
    int waits = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wd; req_tag = tag;
    while (!req_ready && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    n_cmp++;
    if (waits >= 8) begin
      n_err++;
      $display("FAIL accept_timeout: req_ready stayed %0b, wanted 1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    acc_rden = spm_rden; acc_wren = spm_wren; acc_be = spm_store_byteena;
    acc_wd = spm_write_data; acc_wa = spm_wraddress; acc_ra = spm_rdaddress;
  endtask

  // Captures the response at N+2, then handshakes it.
  task automatic finish_op();
    int waits = 0;
    @(posedge clk);
    @(negedge clk);
    r_valid = resp_valid; r_rdata = resp_rdata; r_tag = resp_tag; r_exc = resp_exc;
    resp_ready = 1'b1;
    while (!resp_valid && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    r_after = resp_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0; req_tag = 6'h0;
    #12;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %0b want 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %0b want 0", resp_valid); end
    n_cmp++; if ({resp_rdata, resp_tag, resp_exc} !== 40'h0) begin n_err++; $display("FAIL rst_resp_fields: got %h/%h/%b want 0", resp_rdata, resp_tag, resp_exc); end
    n_cmp++; if ({spm_rden, spm_wren, spm_store_byteena, spm_write_data, spm_rdaddress, spm_wraddress} !== 102'h0) begin
      n_err++; $display("FAIL rst_spm: rden %0b wren %0b be %b wd %h ra %h wa %h want all 0",
                        spm_rden, spm_wren, spm_store_byteena, spm_write_data, spm_rdaddress, spm_wraddress);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word();
    start_op(1'b1, 3'b010, 32'h10, 32'h11223344, 6'd5);
    n_cmp++; if ({acc_wren, acc_rden} !== 2'b10) begin n_err++; $display("FAIL sw_strobes: wren %0b rden %0b want 1/0", acc_wren, acc_rden); end
    n_cmp++; if (acc_be !== 4'b1111) begin n_err++; $display("FAIL sw_byteena: got %b want 1111", acc_be); end
    n_cmp++; if (acc_wd !== 32'h11223344) begin n_err++; $display("FAIL sw_wdata: got %h want 11223344", acc_wd); end
    n_cmp++; if (acc_wa !== 32'h10) begin n_err++; $display("FAIL sw_waddr: got %h want 00000010", acc_wa); end
    finish_op();
    n_cmp++; if (r_valid !== 1'b1) begin n_err++; $display("FAIL sw_resp_latency: resp_valid %0b at N+2 want 1", r_valid); end
    n_cmp++; if ({r_rdata, r_tag, r_exc} !== {32'h0, 6'd5, 2'b00}) begin n_err++; $display("FAIL sw_resp: got %h/%0d/%b want 0/5/00", r_rdata, r_tag, r_exc); end
    n_cmp++; if (r_after !== 1'b0) begin n_err++; $display("FAIL sw_resp_drop: resp_valid %0b after handshake want 0", r_after); end
    start_op(1'b0, 3'b010, 32'h10, 32'h0, 6'd6);
    n_cmp++; if ({acc_rden, acc_wren, acc_ra} !== {2'b10, 32'h10}) begin n_err++; $display("FAIL lw_strobes: rden %0b wren %0b ra %h want 1/0/10", acc_rden, acc_wren, acc_ra); end
    finish_op();
    n_cmp++; if ({r_valid, r_rdata, r_tag, r_exc} !== {1'b1, 32'h11223344, 6'd6, 2'b00}) begin n_err++; $display("FAIL lw_resp: got v%0b %h/%0d/%b want v1 11223344/6/00", r_valid, r_rdata, r_tag, r_exc); end
  endtask

  task automatic test_byte();
    start_op(1'b1, 3'b010, 32'h10, 32'h80FF0011, 6'd1); finish_op();
    start_op(1'b0, 3'b000, 32'h11, 32'h0, 6'd2); finish_op();
    n_cmp++; if (r_rdata !== 32'hFFFFFFFF) begin n_err++; $display("FAIL lb_11: got %h want FFFFFFFF", r_rdata); end
    start_op(1'b0, 3'b100, 32'h13, 32'h0, 6'd3); finish_op();
    n_cmp++; if (r_rdata !== 32'h00000011) begin n_err++; $display("FAIL lbu_13: got %h want 00000011", r_rdata); end
    start_op(1'b0, 3'b000, 32'h10, 32'h0, 6'd4); finish_op();
    n_cmp++; if (r_rdata !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_10: got %h want FFFFFF80", r_rdata); end
    start_op(1'b0, 3'b100, 32'h11, 32'h0, 6'd7); finish_op();
    n_cmp++; if (r_rdata !== 32'h000000FF) begin n_err++; $display("FAIL lbu_11: got %h want 000000FF", r_rdata); end
    start_op(1'b1, 3'b000, 32'h12, 32'h123456AB, 6'd8);
    n_cmp++; if ({acc_be, acc_wd, acc_wa} !== {4'b0010, 32'h0000AB00, 32'h10}) begin n_err++; $display("FAIL sb_12: be %b wd %h wa %h want 0010/0000AB00/10", acc_be, acc_wd, acc_wa); end
    finish_op();
    start_op(1'b0, 3'b010, 32'h10, 32'h0, 6'd9); finish_op();
    n_cmp++; if (r_rdata !== 32'h80FFAB11) begin n_err++; $display("FAIL lw_after_sb: got %h want 80FFAB11", r_rdata); end
  endtask

  task automatic test_half();
    start_op(1'b1, 3'b001, 32'h22, 32'h0000BEEF, 6'd10);
    n_cmp++; if ({acc_wren, acc_wa, acc_be, acc_wd} !== {1'b1, 32'h20, 4'b0011, 32'h0000BEEF}) begin n_err++; $display("FAIL sh_22: wren %0b wa %h be %b wd %h want 1/20/0011/0000BEEF", acc_wren, acc_wa, acc_be, acc_wd); end
    finish_op();
    start_op(1'b0, 3'b001, 32'h22, 32'h0, 6'd11); finish_op();
    n_cmp++; if (r_rdata !== 32'hFFFFBEEF) begin n_err++; $display("FAIL lh_22: got %h want FFFFBEEF", r_rdata); end
    start_op(1'b0, 3'b101, 32'h22, 32'h0, 6'd12); finish_op();
    n_cmp++; if (r_rdata !== 32'h0000BEEF) begin n_err++; $display("FAIL lhu_22: got %h want 0000BEEF", r_rdata); end
    start_op(1'b1, 3'b001, 32'h20, 32'hFFFF1234, 6'd13);
    n_cmp++; if ({acc_be, acc_wd} !== {4'b1100, 32'h12340000}) begin n_err++; $display("FAIL sh_20: be %b wd %h want 1100/12340000", acc_be, acc_wd); end
    finish_op();
    start_op(1'b0, 3'b010, 32'h20, 32'h0, 6'd14); finish_op();
    n_cmp++; if (r_rdata !== 32'h1234BEEF) begin n_err++; $display("FAIL lw_20: got %h want 1234BEEF", r_rdata); end
    start_op(1'b0, 3'b001, 32'h20, 32'h0, 6'd15); finish_op();
    n_cmp++; if (r_rdata !== 32'h00001234) begin n_err++; $display("FAIL lh_20: got %h want 00001234", r_rdata); end
  endtask

  task automatic test_faults();
    start_op(1'b0, 3'b010, 32'h06, 32'h0, 6'd20);
    n_cmp++; if ({acc_rden, acc_wren} !== 2'b00) begin n_err++; $display("FAIL lw_06_strobe: rden %0b wren %0b want 0/0", acc_rden, acc_wren); end
    finish_op();
    n_cmp++; if ({r_valid, r_exc, r_rdata, r_tag} !== {1'b1, 2'b01, 32'h0, 6'd20}) begin n_err++; $display("FAIL lw_06_resp: v%0b exc %b rdata %h tag %0d want v1 01 0 20", r_valid, r_exc, r_rdata, r_tag); end
    start_op(1'b0, 3'b011, 32'h10, 32'h0, 6'd21);
    n_cmp++; if (acc_rden !== 1'b0) begin n_err++; $display("FAIL ld_f3_011_strobe: rden %0b want 0", acc_rden); end
    finish_op();
    n_cmp++; if ({r_exc, r_rdata} !== {2'b11, 32'h0}) begin n_err++; $display("FAIL ld_f3_011: exc %b rdata %h want 11/0", r_exc, r_rdata); end
    start_op(1'b0, 3'b110, 32'h01, 32'h0, 6'd22); finish_op();
    n_cmp++; if (r_exc !== 2'b11) begin n_err++; $display("FAIL ld_f3_110_priority: exc %b want 11", r_exc); end
    start_op(1'b0, 3'b101, 32'h23, 32'h0, 6'd23); finish_op();
    n_cmp++; if (r_exc !== 2'b01) begin n_err++; $display("FAIL lhu_23: exc %b want 01", r_exc); end
    start_op(1'b1, 3'b010, 32'h02, 32'hFFFFFFFF, 6'd24);
    n_cmp++; if (acc_wren !== 1'b0) begin n_err++; $display("FAIL sw_02_strobe: wren %0b want 0", acc_wren); end
    finish_op();
    n_cmp++; if (r_exc !== 2'b01) begin n_err++; $display("FAIL sw_02: exc %b want 01", r_exc); end
    start_op(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 6'd25);
    n_cmp++; if (acc_wren !== 1'b0) begin n_err++; $display("FAIL st_f3_100_strobe: wren %0b want 0", acc_wren); end
    finish_op();
    n_cmp++; if (r_exc !== 2'b11) begin n_err++; $display("FAIL st_f3_100: exc %b want 11", r_exc); end
  endtask

  task automatic test_range();
    start_op(1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 6'd30);
`ifdef LSU_ACCESS_FAULT_EN
    n_cmp++; if (acc_wren !== 1'b0) begin n_err++; $display("FAIL sw_400_strobe: wren %0b want 0", acc_wren); end
    finish_op();
    n_cmp++; if (r_exc !== 2'b10) begin n_err++; $display("FAIL sw_400: exc %b want 10", r_exc); end
    start_op(1'b0, 3'b010, 32'h402, 32'h0, 6'd31); finish_op();
    n_cmp++; if (r_exc !== 2'b01) begin n_err++; $display("FAIL lw_402_priority: exc %b want 01", r_exc); end
    start_op(1'b0, 3'b010, 32'h0, 32'h0, 6'd32); finish_op();
    n_cmp++; if (r_rdata !== 32'h0) begin n_err++; $display("FAIL lw_0_untouched: got %h want 00000000", r_rdata); end
`else
    n_cmp++; if ({acc_wren, acc_wa} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL sw_400_wrap: wren %0b wa %h want 1/00000000", acc_wren, acc_wa); end
    finish_op();
    n_cmp++; if (r_exc !== 2'b00) begin n_err++; $display("FAIL sw_400: exc %b want 00", r_exc); end
    start_op(1'b0, 3'b010, 32'h0, 32'h0, 6'd31); finish_op();
    n_cmp++; if (r_rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL lw_0_wrap: got %h want CAFEF00D", r_rdata); end
    start_op(1'b0, 3'b010, 32'h410, 32'h0, 6'd32); finish_op();
    n_cmp++; if ({r_exc, r_rdata} !== {2'b00, 32'h80FFAB11}) begin n_err++; $display("FAIL lw_410_wrap: exc %b rdata %h want 00/80FFAB11", r_exc, r_rdata); end
`endif
  endtask

  task automatic test_flush();
    start_op(1'b1, 3'b010, 32'h30, 32'hDEADBEEF, 6'd40);
    flush = 1'b1;
    #1;
    n_cmp++; if (spm_wren !== 1'b0) begin n_err++; $display("FAIL flush_acc_wren: got %0b want 0", spm_wren); end
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL flush_idle_ready: got %0b want 0", req_ready); end
    flush = 1'b0;
    #1;
    n_cmp++; if ({resp_valid, req_ready} !== 2'b01) begin n_err++; $display("FAIL flush_after: resp_valid %0b req_ready %0b want 0/1", resp_valid, req_ready); end
    @(negedge clk);
    start_op(1'b0, 3'b010, 32'h30, 32'h0, 6'd41); finish_op();
    n_cmp++; if (r_rdata !== 32'h0) begin n_err++; $display("FAIL flush_no_write: got %h want 00000000", r_rdata); end
    start_op(1'b0, 3'b010, 32'h10, 32'h0, 6'd42);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_cmp++; if ({resp_valid, req_ready} !== 2'b01) begin n_err++; $display("FAIL flush_resp: resp_valid %0b req_ready %0b want 0/1", resp_valid, req_ready); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int bad = 0;
    start_op(1'b0, 3'b010, 32'h10, 32'h0, 6'd9);
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if ({resp_valid, resp_rdata, resp_tag, resp_exc} !== {1'b1, 32'h80FFAB11, 6'd9, 2'b00}) begin
        n_err++; bad++;
        $display("FAIL hold_cycle%0d: v%0b %h/%0d/%b want v1 80FFAB11/9/00", c, resp_valid, resp_rdata, resp_tag, resp_exc);
      end
      n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL hold_ready%0d: got %0b want 0", c, req_ready); end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    n_cmp++; if ({resp_valid, req_ready} !== 2'b01) begin n_err++; $display("FAIL hold_release: resp_valid %0b req_ready %0b want 0/1", resp_valid, req_ready); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_faults();
    test_range();
    test_flush();
    test_backpressure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, wanted completion");
    $fatal(1, "timeout");
  end

endmodule
